// File: rtl/qtcore_multi_frontend_if.sv
// Pin/core bus for qtcore_multi_frontend.
// slave  : the front-end itself.
// master : its environment, i.e. the pin wrapper that drives the selects and
//          scan data, together with the core array returning scan_out/halt.
interface qtcore_multi_frontend_if #(
    parameter int NUM_CORES = 2,
    parameter int SEL_W     = 3
);
    logic                 cs_scan_n;
    logic                 cs_proc_n;
    logic [SEL_W-1:0]     core_sel;
    logic                 scan_in;
    logic                 miso;
    logic [NUM_CORES-1:0] core_scan_enable;
    logic [NUM_CORES-1:0] core_proc_en;
    logic                 core_scan_in;
    logic [NUM_CORES-1:0] core_scan_out;
    logic [NUM_CORES-1:0] core_halt;

    modport master (
        output cs_scan_n, cs_proc_n, core_sel, scan_in, core_scan_out, core_halt,
        input  miso, core_scan_enable, core_proc_en, core_scan_in
    );

    modport slave (
        input  cs_scan_n, cs_proc_n, core_sel, scan_in, core_scan_out, core_halt,
        output miso, core_scan_enable, core_proc_en, core_scan_in
    );
endinterface

// File: rtl/qtcore_multi_frontend.sv
// qtcore_multi_frontend: one SPI-style pin set fanned out to NUM_CORES cores.
// The chip selects are registered once, then a small session FSM latches the
// target core at session start and steers scan/run enables and miso to it.
// Optional feature macro: QTCORE_SCAN_BITCOUNT_EN. It adds a scan-length
// checker with the output bitcount_err.
module qtcore_multi_frontend #(
    parameter int NUM_CORES = 2,
    parameter int SEL_W     = 3,
    parameter int CHAIN_LEN = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    qtcore_multi_frontend_if.slave bus,
    output logic [NUM_CORES-1:0]  halt_seen,
    output logic                  conflict
`ifdef QTCORE_SCAN_BITCOUNT_EN
    ,
    output logic                  bitcount_err
`endif
);
    typedef enum logic [1:0] {IDLE, SCAN, RUN, BLOCKED} state_t;

    state_t           state;
    state_t           state_nxt;
    logic             scan_q;
    logic             proc_q;
    logic             din_q;
    logic             din_qq;
    logic [SEL_W-1:0] sel_q;
    logic [SEL_W-1:0] sel_lat;
    logic             sel_ok;
    logic             start_scan;
    logic             start_run;

    // Reject impossible configurations at elaboration time.
    if (NUM_CORES < 1 || NUM_CORES > 8 || (1 << SEL_W) < NUM_CORES || CHAIN_LEN < 1) begin : g_param_check
        $error("qtcore_multi_frontend: illegal parameter combination");
    end

    // Input stage: one register per pin, plus a second data flop so the first
    // scan bit reaches the cores in the same cycle as the enable.
    // NOTE: non-blocking (<=) on every flop so each one samples pre-edge values.
    always_ff @(posedge clk) begin
        if (!rst) begin
            scan_q <= 1'b1;
            proc_q <= 1'b1;
            sel_q  <= '0;
            din_q  <= 1'b0;
            din_qq <= 1'b0;
        end else begin
            scan_q <= bus.cs_scan_n;
            proc_q <= bus.cs_proc_n;
            sel_q  <= bus.core_sel;
            din_q  <= bus.scan_in;
            din_qq <= din_q;
        end
    end

    assign bus.core_scan_in = din_qq;
    assign sel_ok           = 32'(sel_q) < NUM_CORES;

    // Session next-state logic; BLOCKED has priority over any clean exit.
    // NOTE: default assigned first so no path leaves state_nxt unassigned (no latch).
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (!scan_q || !proc_q) begin
                    if ((!scan_q && !proc_q) || !sel_ok) state_nxt = BLOCKED;
                    else if (!scan_q)                    state_nxt = SCAN;
                    else                                 state_nxt = RUN;
                end
            end
            SCAN: begin
                if (!proc_q)     state_nxt = BLOCKED;
                else if (scan_q) state_nxt = IDLE;
            end
            RUN: begin
                if (!scan_q)     state_nxt = BLOCKED;
                else if (proc_q) state_nxt = IDLE;
            end
            BLOCKED: begin
                if (scan_q && proc_q) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    assign start_scan = (state == IDLE) && (state_nxt == SCAN);
    assign start_run  = (state == IDLE) && (state_nxt == RUN);

    // State register, per-session core latch and sticky halt flags.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state     <= IDLE;
            sel_lat   <= '0;
            halt_seen <= '0;
        end else begin
            state <= state_nxt;
            if (start_scan || start_run) sel_lat <= sel_q;
            for (int i = 0; i < NUM_CORES; i++) begin
                if (start_run && sel_q == SEL_W'(i))
                    halt_seen[i] <= 1'b0;
                else if (state == RUN && sel_lat == SEL_W'(i) && bus.core_halt[i])
                    halt_seen[i] <= 1'b1;
            end
        end
    end

    // Enable steering and miso mux from state and latched core.
    always_comb begin
        bus.core_scan_enable = '0;
        bus.core_proc_en     = '0;
        bus.miso             = 1'b0;
        for (int i = 0; i < NUM_CORES; i++) begin
            if (sel_lat == SEL_W'(i)) begin
                if (state == SCAN) begin
                    bus.core_scan_enable[i] = 1'b1;
                    bus.miso                = bus.core_scan_out[i];
                end else if (state == RUN) begin
                    bus.core_proc_en[i] = 1'b1;
                    bus.miso            = bus.core_halt[i];
                end
            end
        end
    end

    assign conflict = (state == BLOCKED);

`ifdef QTCORE_SCAN_BITCOUNT_EN
    logic [15:0] bit_cnt;
    logic [15:0] bit_cnt_inc;

    // bit_cnt_inc counts the current SCAN cycle too, so it is the session
    // length at the exit edge.
    assign bit_cnt_inc = (&bit_cnt) ? bit_cnt : bit_cnt + 16'd1;

    // Saturating scan-length counter and its sticky verdict.
    always_ff @(posedge clk) begin
        if (!rst) begin
            bit_cnt      <= '0;
            bitcount_err <= 1'b0;
        end else begin
            if (start_scan)         bit_cnt <= '0;
            else if (state == SCAN) bit_cnt <= bit_cnt_inc;

            if (state == SCAN && state_nxt == IDLE)
                bitcount_err <= (bit_cnt_inc != 16'(CHAIN_LEN));
            else if (state == SCAN && state_nxt == BLOCKED)
                bitcount_err <= 1'b1;
        end
    end
`endif
endmodule
